// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding,
// shared-counter width helper and lock-loss counter width.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAIL      = 3'd5
    } seq_state_e;

    localparam int LOCK_LOST_W = 8;

    // One extra bit beyond the largest cycle count keeps every reload value in range.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/pll_rst_seq_if.sv
// Status/control bundle between the reset sequencer (master) and the
// PLL / clock-domain side (slave).
interface pll_rst_seq_if #(
    parameter int N_DOMAINS = 4
);
    import pll_seq_pkg::*;

    logic                   pll_extlock;
    logic                   sw_reset_req;
    logic                   pll_reset;
    logic [N_DOMAINS-1:0]   dom_rst_n;
    logic                   sys_ready;
    logic [LOCK_LOST_W-1:0] lock_lost_cnt;
    logic                   pll_fail;
    logic [2:0]             state_o;

    modport master (
        input  pll_extlock, sw_reset_req,
        output pll_reset, dom_rst_n, sys_ready, lock_lost_cnt, pll_fail, state_o
    );

    modport slave (
        output pll_extlock, sw_reset_req,
        input  pll_reset, dom_rst_n, sys_ready, lock_lost_cnt, pll_fail, state_o
    );

endinterface

// File: rtl/lock_sync.sv
// Multi-flop synchroniser bringing the asynchronous PLL lock flag into the
// reference clock domain; clears to "not locked" on reset.
module lock_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    assign sync_d[0] = d;

    genvar gi;
    generate
        for (gi = 1; gi < STAGES; gi++) begin : g_stage
            assign sync_d[gi] = sync_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: holds the PLL in reset, qualifies lock, then releases
// domain resets in staggered order. PLLSEQ_RETRY_LIMIT_EN enables the FAIL state.
module pll_rst_seq #(
    parameter int N_DOMAINS        = 4,
    parameter int SYNC_STAGES      = 2,
    parameter int PLL_RST_CYC      = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int STAGGER_CYC      = 8,
    parameter int MAX_RETRY        = 7
) (
    input  logic          refclk,
    input  logic          rst_n,
    pll_rst_seq_if.master bus
);
    import pll_seq_pkg::*;

    localparam int CW = cnt_width(PLL_RST_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC, STAGGER_CYC);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [CW-1:0] RST_LD   = CW'(PLL_RST_CYC - 1);
    localparam logic [CW-1:0] TOUT_LD  = CW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] STAB_LD  = CW'(LOCK_STABLE_CYC - 1);
    localparam logic [CW-1:0] STAG_LD  = CW'(STAGGER_CYC - 1);
    localparam logic [RW-1:0] RETRY_MX = RW'(MAX_RETRY);

    seq_state_e             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [N_DOMAINS-1:0]   dom_q, dom_d;
    logic [LOCK_LOST_W-1:0] llc_q, llc_d, llc_inc;
    logic [RW-1:0]          retry_q, retry_d, retry_inc;
    logic                   pll_reset_q, pll_reset_d;
    logic                   sys_ready_q, sys_ready_d;
    logic                   lock_s;

    lock_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (bus.pll_extlock),
        .q     (lock_s)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dom_d     = dom_q;
        llc_d     = llc_q;
        retry_d   = retry_q;
        llc_inc   = (llc_q == '1) ? llc_q : llc_q + 1'b1;
        retry_inc = (retry_q == RETRY_MX) ? retry_q : retry_q + 1'b1;

        case (state_q)
            PLL_RST: begin
                if (cnt_q == '0) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = TOUT_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (bus.sw_reset_req) begin
                    state_d = PLL_RST;
                    cnt_d   = RST_LD;
                    retry_d = '0;
                end else if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = STAB_LD;
                end else if (cnt_q == '0) begin
                    state_d = PLL_RST;
                    cnt_d   = RST_LD;
                    retry_d = retry_inc;
`ifdef PLLSEQ_RETRY_LIMIT_EN
                    if (retry_inc == RETRY_MX) state_d = FAIL;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STABLE: begin
                if (bus.sw_reset_req) begin
                    state_d = PLL_RST;
                    cnt_d   = RST_LD;
                    retry_d = '0;
                end else if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = TOUT_LD;
                end else if (cnt_q == '0) begin
                    state_d = RELEASE;
                    cnt_d   = STAG_LD;
                    retry_d = '0;
                    dom_d   = N_DOMAINS'(1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RELEASE, RUN: begin
                // Lock loss wins over a simultaneous software request so it is counted.
                if (!lock_s) begin
                    state_d = PLL_RST;
                    cnt_d   = RST_LD;
                    llc_d   = llc_inc;
                end else if (bus.sw_reset_req) begin
                    state_d = PLL_RST;
                    cnt_d   = RST_LD;
                    retry_d = '0;
                end else if (state_q == RELEASE) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (dom_q[N_DOMAINS-1]) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        dom_d = (dom_q << 1) | N_DOMAINS'(1);
                        cnt_d = STAG_LD;
                    end
                end
            end
            FAIL: begin
                if (bus.sw_reset_req) begin
                    state_d = PLL_RST;
                    cnt_d   = RST_LD;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = PLL_RST;
                cnt_d   = RST_LD;
            end
        endcase

        if (state_d != RELEASE && state_d != RUN) dom_d = '0;
        pll_reset_d = (state_d == PLL_RST) || (state_d == FAIL);
        sys_ready_d = (state_d == RUN);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PLL_RST;
            cnt_q       <= RST_LD;
            dom_q       <= '0;
            llc_q       <= '0;
            retry_q     <= '0;
            pll_reset_q <= 1'b1;
            sys_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dom_q       <= dom_d;
            llc_q       <= llc_d;
            retry_q     <= retry_d;
            pll_reset_q <= pll_reset_d;
            sys_ready_q <= sys_ready_d;
        end
    end

`ifdef PLLSEQ_RETRY_LIMIT_EN
    logic pll_fail_q;
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) pll_fail_q <= 1'b0;
        else        pll_fail_q <= (state_d == FAIL);
    end
    assign bus.pll_fail = pll_fail_q;
`else
    assign bus.pll_fail = 1'b0;
`endif

    assign bus.pll_reset     = pll_reset_q;
    assign bus.dom_rst_n     = dom_q;
    assign bus.sys_ready     = sys_ready_q;
    assign bus.lock_lost_cnt = llc_q;
    assign bus.state_o       = state_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq with small timing parameters; FAIL-state
// checks apply when PLLSEQ_RETRY_LIMIT_EN is defined.
module tb_pll_rst_seq;

    localparam logic [2:0] S_PLL_RST = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_STABLE  = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_RUN     = 3'd4;
    localparam logic [2:0] S_DEAD    = 3'd5;

    logic refclk;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    pll_rst_seq_if #(.N_DOMAINS(4)) bus ();

    pll_rst_seq #(
        .N_DOMAINS        (4),
        .SYNC_STAGES      (2),
        .PLL_RST_CYC      (4),
        .LOCK_STABLE_CYC  (16),
        .LOCK_TIMEOUT_CYC (64),
        .STAGGER_CYC      (2),
        .MAX_RETRY        (3)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (bus.master)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
        int n;
        n = 0;
        while (bus.state_o !== st && n < budget) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(bus.state_o), 32'(st));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        bus.pll_extlock  = 1'b0;
        bus.sw_reset_req = 1'b0;
        tick(3);

        // Reset values
        chk("rst_pll_reset", 32'(bus.pll_reset), 32'd1);
        chk("rst_dom", 32'(bus.dom_rst_n), 32'd0);
        chk("rst_sys_ready", 32'(bus.sys_ready), 32'd0);
        chk("rst_llc", 32'(bus.lock_lost_cnt), 32'd0);
        chk("rst_pll_fail", 32'(bus.pll_fail), 32'd0);
        chk("rst_state", 32'(bus.state_o), 32'(S_PLL_RST));

        // 1. Nominal: cycle 0 is the period before the first edge after release
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("nom_pll_reset_hold", 32'(bus.pll_reset), 32'd1);
            tick(1);
        end
        chk("nom_wait_state", 32'(bus.state_o), 32'(S_WAIT));
        chk("nom_pll_reset_low", 32'(bus.pll_reset), 32'd0);
        tick(6);
        bus.pll_extlock = 1'b1;
        tick(18);
        chk("nom_stable_e28", 32'(bus.state_o), 32'(S_STABLE));
        chk("nom_dom_e28", 32'(bus.dom_rst_n), 32'h0);
        tick(1);
        chk("nom_release_e29", 32'(bus.state_o), 32'(S_RELEASE));
        chk("nom_dom_e29", 32'(bus.dom_rst_n), 32'h1);
        tick(1);
        chk("nom_dom_e30", 32'(bus.dom_rst_n), 32'h1);
        tick(1);
        chk("nom_dom_e31", 32'(bus.dom_rst_n), 32'h3);
        tick(2);
        chk("nom_dom_e33", 32'(bus.dom_rst_n), 32'h7);
        tick(2);
        chk("nom_dom_e35", 32'(bus.dom_rst_n), 32'hF);
        chk("nom_ready_e35", 32'(bus.sys_ready), 32'd0);
        tick(1);
        chk("nom_ready_e36", 32'(bus.sys_ready), 32'd0);
        tick(1);
        chk("nom_ready_e37", 32'(bus.sys_ready), 32'd1);
        chk("nom_run_e37", 32'(bus.state_o), 32'(S_RUN));

        // 5b. Software request alone in RUN: resequence, no lock-loss count
        bus.sw_reset_req = 1'b1;
        tick(1);
        bus.sw_reset_req = 1'b0;
        chk("sw_state", 32'(bus.state_o), 32'(S_PLL_RST));
        chk("sw_dom", 32'(bus.dom_rst_n), 32'h0);
        chk("sw_pll_reset", 32'(bus.pll_reset), 32'd1);
        chk("sw_sys_ready", 32'(bus.sys_ready), 32'd0);
        chk("sw_llc", 32'(bus.lock_lost_cnt), 32'd0);

        // 2. Lock glitch after 10 cycles of STABLE
        tick(5);
        chk("gl_stable_e43", 32'(bus.state_o), 32'(S_STABLE));
        tick(9);
        bus.pll_extlock = 1'b0;
        tick(3);
        bus.pll_extlock = 1'b1;
        chk("gl_wait_e55", 32'(bus.state_o), 32'(S_WAIT));
        tick(2);
        chk("gl_wait_e57", 32'(bus.state_o), 32'(S_WAIT));
        tick(1);
        chk("gl_stable_e58", 32'(bus.state_o), 32'(S_STABLE));
        tick(15);
        chk("gl_stable_e73", 32'(bus.state_o), 32'(S_STABLE));
        chk("gl_dom_e73", 32'(bus.dom_rst_n), 32'h0);
        tick(1);
        chk("gl_release_e74", 32'(bus.state_o), 32'(S_RELEASE));
        chk("gl_dom_e74", 32'(bus.dom_rst_n), 32'h1);
        tick(8);
        chk("gl_run_e82", 32'(bus.state_o), 32'(S_RUN));
        chk("gl_ready_e82", 32'(bus.sys_ready), 32'd1);

        // 3. Lock loss in RUN: detected exactly three edges after the drop
        bus.pll_extlock = 1'b0;
        tick(2);
        chk("loss_dom_still_up", 32'(bus.dom_rst_n), 32'hF);
        tick(1);
        chk("loss_state", 32'(bus.state_o), 32'(S_PLL_RST));
        chk("loss_dom", 32'(bus.dom_rst_n), 32'h0);
        chk("loss_pll_reset", 32'(bus.pll_reset), 32'd1);
        chk("loss_sys_ready", 32'(bus.sys_ready), 32'd0);
        chk("loss_llc", 32'(bus.lock_lost_cnt), 32'd1);

        // 5a. Software request in the same cycle lock_s falls
        bus.pll_extlock = 1'b1;
        wait_state(S_RUN, 100, "same_reach_run");
        bus.pll_extlock = 1'b0;
        tick(2);
        chk("same_still_run", 32'(bus.state_o), 32'(S_RUN));
        bus.sw_reset_req = 1'b1;
        tick(1);
        bus.sw_reset_req = 1'b0;
        chk("same_state", 32'(bus.state_o), 32'(S_PLL_RST));
        chk("same_llc", 32'(bus.lock_lost_cnt), 32'd2);

        // 3b. Repeated lock loss up to 300 events: counter saturates at 255
        for (int i = 3; i <= 300; i++) begin
            bus.pll_extlock = 1'b1;
            wait_state(S_RUN, 100, "sat_reach_run");
            bus.pll_extlock = 1'b0;
            tick(3);
            chk("sat_llc", 32'(bus.lock_lost_cnt), (i > 255) ? 32'd255 : 32'(i));
        end

        // 6. rst_n asserted mid-RELEASE takes effect without a clock edge
        bus.pll_extlock = 1'b1;
        wait_state(S_RELEASE, 100, "arst_reach_release");
        tick(2);
        chk("arst_pre_dom", 32'(bus.dom_rst_n), 32'h3);
        rst_n = 1'b0;
        #1;
        chk("arst_pll_reset", 32'(bus.pll_reset), 32'd1);
        chk("arst_dom", 32'(bus.dom_rst_n), 32'h0);
        chk("arst_sys_ready", 32'(bus.sys_ready), 32'd0);
        chk("arst_llc", 32'(bus.lock_lost_cnt), 32'd0);
        chk("arst_state", 32'(bus.state_o), 32'(S_PLL_RST));
        bus.pll_extlock = 1'b0;
        tick(2);

        // 4. Timeout with no lock; sw_reset_req inside PLL_RST is ignored
        rst_n = 1'b1;
        chk("to_pll_reset_c0", 32'(bus.pll_reset), 32'd1);
        tick(1);
        bus.sw_reset_req = 1'b1;
        tick(1);
        bus.sw_reset_req = 1'b0;
        tick(2);
        chk("to_wait_e4", 32'(bus.state_o), 32'(S_WAIT));
        chk("to_pll_reset_e4", 32'(bus.pll_reset), 32'd0);
        tick(63);
        chk("to_wait_e67", 32'(bus.state_o), 32'(S_WAIT));
        chk("to_pll_reset_e67", 32'(bus.pll_reset), 32'd0);
        tick(1);
        chk("to_rst_e68", 32'(bus.state_o), 32'(S_PLL_RST));
        chk("to_pll_reset_e68", 32'(bus.pll_reset), 32'd1);
        tick(4);
        chk("to_wait_e72", 32'(bus.state_o), 32'(S_WAIT));
        tick(64);
        chk("to_rst_e136", 32'(bus.state_o), 32'(S_PLL_RST));
        tick(68);
`ifdef PLLSEQ_RETRY_LIMIT_EN
        chk("to_dead_e204", 32'(bus.state_o), 32'(S_DEAD));
        chk("to_pll_fail_e204", 32'(bus.pll_fail), 32'd1);
        tick(10);
        chk("dead_hold_state", 32'(bus.state_o), 32'(S_DEAD));
        chk("dead_hold_fail", 32'(bus.pll_fail), 32'd1);
        chk("dead_pll_reset", 32'(bus.pll_reset), 32'd1);
        chk("dead_dom", 32'(bus.dom_rst_n), 32'h0);
        bus.sw_reset_req = 1'b1;
        tick(1);
        bus.sw_reset_req = 1'b0;
        chk("dead_exit_state", 32'(bus.state_o), 32'(S_PLL_RST));
        chk("dead_exit_fail", 32'(bus.pll_fail), 32'd0);
`else
        chk("to_rst_e204", 32'(bus.state_o), 32'(S_PLL_RST));
        chk("to_pll_fail_e204", 32'(bus.pll_fail), 32'd0);
        tick(10);
        chk("to_pll_fail_later", 32'(bus.pll_fail), 32'd0);
`endif

        // Full sequence replays after the retry phase
        bus.pll_extlock = 1'b1;
        wait_state(S_RUN, 100, "final_reach_run");
        chk("final_dom", 32'(bus.dom_rst_n), 32'hF);
        chk("final_sys_ready", 32'(bus.sys_ready), 32'd1);
        chk("final_llc", 32'(bus.lock_lost_cnt), 32'd0);
        chk("final_pll_fail", 32'(bus.pll_fail), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
